// File: rtl/branch_stack.sv
// Branch checkpoint stack: holds free-list snapshots of in-flight branches and restores one on a mispredict.
// Optional squash_mask output is enabled by defining BRANCH_STACK_SQUASH_MASK_EN.
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module branch_stack #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = `PHYS_REG_SZ_R10K,
    parameter int ID_BITS = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push_valid,
    input  logic [WIDTH-1:0]   push_free_list,
    output logic [ID_BITS-1:0] push_id,
    output logic               full,
    output logic               empty,
    input  logic               resolve_valid,
    input  logic [ID_BITS-1:0] resolve_id,
    input  logic               resolve_mispredict,
    output logic [WIDTH-1:0]   free_list_restore,
    output logic               restore_flag,
    output logic [ID_BITS:0]   count
`ifdef BRANCH_STACK_SQUASH_MASK_EN
    ,
    output logic [DEPTH-1:0]   squash_mask
`endif
);

    logic [ID_BITS-1:0] head_q, head_d;
    logic [ID_BITS-1:0] tail_q, tail_d;
    logic [ID_BITS:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   resolved_q, resolved_d;
    logic [WIDTH-1:0]   restore_q;
    logic               flag_q;
    logic [WIDTH-1:0]   snap_mem [DEPTH];

    logic               mispredict;
    logic               correct;
    logic               pop;
    logic               pop_eff;
    logic               push;
    logic [ID_BITS-1:0] off_k;
    logic [DEPTH-1:0]   squash_vec;

    assign full    = (count_q == (ID_BITS+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_id = tail_q;
    assign count   = count_q;
    assign free_list_restore = restore_q;
    assign restore_flag      = flag_q;

    assign mispredict = resolve_valid && resolve_mispredict && valid_q[resolve_id];
    assign correct    = resolve_valid && !resolve_mispredict && valid_q[resolve_id];
    assign pop        = valid_q[head_q] && resolved_q[head_q];
    // A mispredict on the head squashes everything, so there is nothing left to pop.
    assign pop_eff    = pop && !(mispredict && (resolve_id == head_q));
    // The dispatching branch is younger than any mispredicting one, so it dies with it.
    assign push       = push_valid && !full && !mispredict;
    assign off_k      = resolve_id - head_q;

    // Valid entries occupy head..tail-1, so age order is the offset from head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
            logic [ID_BITS-1:0] off_i;
            assign off_i          = ID_BITS'(gi) - head_q;
            assign squash_vec[gi] = mispredict && valid_q[gi] && (off_i >= off_k);
        end
    endgenerate

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        if (correct) begin
            resolved_d[resolve_id] = 1'b1;
        end
        if (pop_eff) begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
        end
        valid_d    = valid_d & ~squash_vec;
        resolved_d = resolved_d & ~squash_vec;
        if (push) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
        end
        head_d = head_q + ID_BITS'(pop_eff);
        if (mispredict) begin
            tail_d  = resolve_id;
            count_d = {1'b0, off_k} - (ID_BITS+1)'(pop_eff);
        end else begin
            tail_d  = tail_q + ID_BITS'(push);
            count_d = count_q + (ID_BITS+1)'(push) - (ID_BITS+1)'(pop_eff);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            resolved_q <= '0;
            restore_q  <= '0;
            flag_q     <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            flag_q     <= mispredict;
            if (mispredict) begin
                restore_q <= snap_mem[resolve_id];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            snap_mem[tail_q] <= push_free_list;
        end
    end

`ifdef BRANCH_STACK_SQUASH_MASK_EN
    logic [DEPTH-1:0] mask_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= squash_vec;
        end
    end
    assign squash_mask = mask_q;
`endif

endmodule

// File: tb/tb_branch_stack.sv
// Directed bench for branch_stack: a queue-based reference model checked every cycle plus literal spot checks.
module tb_branch_stack;
    localparam int DEPTH = 8;
    localparam int W     = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         push_valid;
    logic [W-1:0] push_free_list;
    logic [2:0]   push_id;
    logic         full;
    logic         empty;
    logic         resolve_valid;
    logic [2:0]   resolve_id;
    logic         resolve_mispredict;
    logic [W-1:0] free_list_restore;
    logic         restore_flag;
    logic [3:0]   count;
`ifdef BRANCH_STACK_SQUASH_MASK_EN
    logic [DEPTH-1:0] squash_mask;
`endif

    branch_stack #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .clock              (clock),
        .reset              (reset),
        .push_valid         (push_valid),
        .push_free_list     (push_free_list),
        .push_id            (push_id),
        .full               (full),
        .empty              (empty),
        .resolve_valid      (resolve_valid),
        .resolve_id         (resolve_id),
        .resolve_mispredict (resolve_mispredict),
        .free_list_restore  (free_list_restore),
        .restore_flag       (restore_flag),
        .count              (count)
`ifdef BRANCH_STACK_SQUASH_MASK_EN
        ,
        .squash_mask        (squash_mask)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ids of live checkpoints in age order, oldest first.
    int               mq[$];
    bit               mres[DEPTH];
    logic [W-1:0]     msnap[DEPTH];
    int               mtail;
    bit               e_flag;
    logic [W-1:0]     e_rest;
    logic [DEPTH-1:0] e_mask;
    bit               started = 0;
    int               pos;
    bit               mpop;
    bit               pre_full;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            mtail   = 0;
            e_flag  = 0;
            e_rest  = '0;
            e_mask  = '0;
            started = 1;
            for (int i = 0; i < DEPTH; i++) mres[i] = 0;
        end else begin
            pos = -1;
            foreach (mq[j]) if (mq[j] == int'(resolve_id)) pos = j;
            mpop     = (mq.size() > 0) && mres[mq[0]];
            pre_full = (mq.size() == DEPTH);
            if (resolve_valid && resolve_mispredict && pos >= 0) begin
                e_mask = '0;
                for (int j = pos; j < mq.size(); j++) e_mask[mq[j]] = 1'b1;
                e_rest = msnap[resolve_id];
                e_flag = 1;
                while (mq.size() > pos) void'(mq.pop_back());
                mtail = int'(resolve_id);
                if (mpop && pos > 0) begin
                    mres[mq[0]] = 0;
                    void'(mq.pop_front());
                end
            end else begin
                e_flag = 0;
                e_mask = '0;
                if (resolve_valid && !resolve_mispredict && pos >= 0) mres[resolve_id] = 1;
                if (mpop) begin
                    mres[mq[0]] = 0;
                    void'(mq.pop_front());
                end
                if (push_valid && !pre_full) begin
                    msnap[mtail] = push_free_list;
                    mres[mtail]  = 0;
                    mq.push_back(mtail);
                    mtail = (mtail + 1) % DEPTH;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("model push_id", push_id, mtail);
            chk("model count", count, mq.size());
            chk("model full", full, mq.size() == DEPTH);
            chk("model empty", empty, mq.size() == 0);
            chk("model restore_flag", restore_flag, e_flag);
            chk("model free_list_restore", free_list_restore, e_rest);
`ifdef BRANCH_STACK_SQUASH_MASK_EN
            chk("model squash_mask", squash_mask, e_mask);
`endif
        end
    end

    task automatic step(input bit pv, input logic [W-1:0] pd, input bit rv, input int rid, input bit rm);
        push_valid         = pv;
        push_free_list     = pd;
        resolve_valid      = rv;
        resolve_id         = rid[2:0];
        resolve_mispredict = rm;
        @(posedge clock);
        @(negedge clock);
        push_valid    = 0;
        resolve_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step(0, '0, 0, 0, 0);
        reset = 0;
    endtask

    initial begin
        reset = 1; push_valid = 0; push_free_list = '0;
        resolve_valid = 0; resolve_id = '0; resolve_mispredict = 0;

        // Reset state, then three pushes.
        do_reset();
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst push_id", push_id, 0);
        chk("rst flag", restore_flag, 0);
        chk("rst restore", free_list_restore, 0);
        step(1, 16'h00A0, 0, 0, 0); chk("push A id", push_id, 1);
        step(1, 16'h00B0, 0, 0, 0); chk("push B id", push_id, 2);
        step(1, 16'h00C0, 0, 0, 0); chk("push C id", push_id, 3);
        chk("3 push count", count, 3);
        chk("3 push empty", empty, 0);

        // Out-of-order correct resolves drain in order on consecutive cycles.
        step(0, '0, 1, 1, 0); chk("res1 count", count, 3);
        step(0, '0, 1, 0, 0); chk("res0 count", count, 3);
        step(0, '0, 0, 0, 0); chk("pop0 count", count, 2);
        step(0, '0, 0, 0, 0); chk("pop1 count", count, 1);

        // Mispredict id 2 with a simultaneous push.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, W'(16'h1000 + i), 0, 0, 0);
        step(1, 16'h0EEE, 1, 2, 1);
        chk("mp flag", restore_flag, 1);
        chk("mp restore", free_list_restore, 16'h1002);
        chk("mp count", count, 2);
        chk("mp push_id", push_id, 2);
`ifdef BRANCH_STACK_SQUASH_MASK_EN
        chk("mp mask", squash_mask, 8'b0001_1100);
`endif
        step(0, '0, 0, 0, 0);
        chk("mp flag drop", restore_flag, 0);
        chk("mp restore hold", free_list_restore, 16'h1002);

        // Full, then a dropped ninth push.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, W'(16'h2000 + i), 0, 0, 0);
        chk("full flag", full, 1);
        chk("full count", count, 8);
        step(1, 16'h2FFF, 0, 0, 0);
        chk("9th count", count, 8);
        chk("9th push_id", push_id, 0);

        // Drain 0..5 to put head at 6, then wrap tail to 2.
        for (int i = 0; i < 6; i++) step(0, '0, 1, i, 0);
        step(0, '0, 0, 0, 0);
        chk("wrap count", count, 2);
        step(1, 16'h3000, 0, 0, 0);
        step(1, 16'h3001, 0, 0, 0);
        chk("wrap count4", count, 4);
        step(0, '0, 1, 7, 1);
        chk("wrap flag", restore_flag, 1);
        chk("wrap restore", free_list_restore, 16'h2007);
        chk("wrap count1", count, 1);
        chk("wrap push_id", push_id, 7);
`ifdef BRANCH_STACK_SQUASH_MASK_EN
        chk("wrap mask", squash_mask, 8'b1000_0011);
`endif
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 0);
        chk("squashed res ignored", count, 1);
        step(0, '0, 1, 6, 0);
        step(0, '0, 0, 0, 0);
        chk("head6 popped", count, 0);

        // Mispredict on an invalid id.
        step(0, '0, 1, 3, 1);
        chk("inv mp flag", restore_flag, 0);
        chk("inv mp restore", free_list_restore, 16'h2007);

        // Reset during a restore pulse.
        step(1, 16'h4000, 0, 0, 0);
        step(1, 16'h4001, 0, 0, 0);
        step(0, '0, 1, 7, 1);
        chk("pulse before rst", restore_flag, 1);
        do_reset();
        chk("rst2 flag", restore_flag, 0);
        chk("rst2 restore", free_list_restore, 0);
        chk("rst2 count", count, 0);
        chk("rst2 push_id", push_id, 0);
        chk("rst2 empty", empty, 1);
        step(0, '0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
